eth_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing the RMII transmit chain (identity -> bitorder -> tether) among NUM_REQ word sources.

---
 rtl/eth_tx_arbiter_if.sv | 18 +
 rtl/eth_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter_if
// Requester-side handshake bundle of the RMII transmit arbiter.
//   req_valid  [NUM_REQ]     requester i has a word pending (held until ready)
//   req_data   [32*NUM_REQ]  word of requester i in bits [32*i+31:32*i]
//   req_ready  [NUM_REQ]     one-cycle accept pulse for requester i
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface eth_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
// Round-robin scheduler sharing the RMII transmit chain (identity -> bitorder
// -> tether) among NUM_REQ word sources. A granted 32-bit word is sent as 16
// dibits MSB first; the arbiter then waits for the chain's txen to fall,
// counts the frame and holds an inter-frame gap of IFG_CYCLES clocks.
// Ports:
//   clk, rst     eth_refclk and synchronous active-high reset
//   req          eth_tx_arbiter_if.slave (req_valid/req_data/req_ready)
//   txen_in      eth_txen fed back from tether
//   axiov/axiod  dibit valid / dibit into identity
//   busy         high in every state except IDLE
//   grant_idx    index of last granted requester
//   frames_sent  completed-frame count, wraps modulo 2^16
//   tx_timeout   (only with ETH_TX_ARB_TIMEOUT_EN) sticky WAIT_TX timeout flag
// Build option: ETH_TX_ARB_TIMEOUT_EN adds a 1024-clock WAIT_TX timeout.
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  eth_tx_arbiter_if.slave            req,
  input  logic                       txen_in,
  output logic                       axiov,
  output logic [1:0]                 axiod,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic [15:0]                frames_sent
`ifdef ETH_TX_ARB_TIMEOUT_EN
  ,
  output logic                       tx_timeout
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, GAP} state_t;

  state_t             state_q;
  logic [31:0]        shreg_q;
  logic [3:0]         dibit_cnt_q;
  logic [GW-1:0]      gap_cnt_q;
  logic               txen_prev_q;
  logic               axiov_q;
  logic [1:0]         axiod_q;
  logic               busy_q;
  logic [IW-1:0]      grant_idx_q;
  logic [15:0]        frames_sent_q;
  logic [NUM_REQ-1:0] ready_q;
`ifdef ETH_TX_ARB_TIMEOUT_EN
  logic [9:0]         wait_cnt_q;
  logic               tx_timeout_q;
`endif

  // Round-robin pick: first valid requester after the last grant, wrapping.
  logic          win_found_d;
  logic [IW-1:0] win_idx_d;
  logic [IW-1:0] cand_idx;
  logic [31:0]   win_data_d;

  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = grant_idx_q;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IW'((32'(grant_idx_q) + k) % NUM_REQ);
      if (!win_found_d && req.req_valid[cand_idx]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_idx;
      end
    end
    win_data_d = req.req_data[32*win_idx_d +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      dibit_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      txen_prev_q   <= 1'b0;
      axiov_q       <= 1'b0;
      axiod_q       <= '0;
      busy_q        <= 1'b0;
      grant_idx_q   <= IW'(NUM_REQ - 1);
      frames_sent_q <= '0;
      ready_q       <= '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      tx_timeout_q  <= 1'b0;
`endif
    end else begin
      txen_prev_q <= txen_in;
      ready_q     <= '0;
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            // The first dibit is launched at grant time so it is on the
            // wire during the first SEND cycle, alongside req_ready.
            axiov_q            <= 1'b1;
            axiod_q            <= win_data_d[31:30];
            shreg_q            <= {win_data_d[29:0], 2'b00};
            grant_idx_q        <= win_idx_d;
            ready_q[win_idx_d] <= 1'b1;
            busy_q             <= 1'b1;
            dibit_cnt_q        <= '0;
            state_q            <= SEND;
          end
        end
        SEND: begin
          if (dibit_cnt_q == 4'd15) begin
            axiov_q     <= 1'b0;
            axiod_q     <= '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
            state_q     <= WAIT_TX;
          end else begin
            axiod_q     <= shreg_q[31:30];
            shreg_q     <= {shreg_q[29:0], 2'b00};
            dibit_cnt_q <= dibit_cnt_q + 4'd1;
          end
        end
        WAIT_TX: begin
          if (txen_prev_q && !txen_in) begin
            frames_sent_q <= frames_sent_q + 16'd1;
            gap_cnt_q     <= '0;
            state_q       <= GAP;
          end
`ifdef ETH_TX_ARB_TIMEOUT_EN
          else if (wait_cnt_q == 10'd1023) begin
            tx_timeout_q <= 1'b1;
            gap_cnt_q    <= '0;
            state_q      <= GAP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 10'd1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt_q == GW'(IFG_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign axiov         = axiov_q;
  assign axiod         = axiod_q;
  assign busy          = busy_q;
  assign grant_idx     = grant_idx_q;
  assign frames_sent   = frames_sent_q;
`ifdef ETH_TX_ARB_TIMEOUT_EN
  assign tx_timeout    = tx_timeout_q;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arbiter
// Directed bench for eth_tx_arbiter (NUM_REQ=2, IFG_CYCLES=48). A small tether
// model echoes axiov back as txen delayed by four clocks. The timeout scenario
// is included only when ETH_TX_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_eth_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IFG     = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        txen_in;
  logic        axiov;
  logic [1:0]  axiod;
  logic        busy;
  logic [0:0]  grant_idx;
  logic [15:0] frames_sent;
`ifdef ETH_TX_ARB_TIMEOUT_EN
  logic        tx_timeout;
`endif

  eth_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  eth_tx_arbiter #(.NUM_REQ(NUM_REQ), .IFG_CYCLES(IFG)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (bus),
    .txen_in     (txen_in),
    .axiov       (axiov),
    .axiod       (axiod),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .frames_sent (frames_sent)
`ifdef ETH_TX_ARB_TIMEOUT_EN
    ,
    .tx_timeout  (tx_timeout)
`endif
  );

  always #10 clk = ~clk;

  // Tether model: txen follows axiov four clocks later, reset with the chain.
  logic [3:0] dly_q;
  logic       tether_en;
  always @(posedge clk) begin
    if (rst) dly_q <= '0;
    else     dly_q <= {dly_q[2:0], axiov};
  end
  assign txen_in = dly_q[3] & tether_en;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-sample monitors: ready pulse counts and txen-fall to axiov-rise spacing.
  int   cyc = 0;
  int   fall_cyc = 0;
  bit   fall_seen = 1'b0;
  bit   ifg_chk = 1'b0;
  logic prev_txen = 1'b0;
  logic prev_axiov = 1'b0;
  int   rdy0 = 0;
  int   rdy1 = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.req_ready[0]) rdy0++;
    if (bus.req_ready[1]) rdy1++;
    if (prev_txen && !txen_in) begin
      fall_cyc  = cyc;
      fall_seen = 1'b1;
    end
    // Fall sampled at S: DUT detects at S+1, gap S+2..S+49, grant at S+50.
    if (ifg_chk && fall_seen && !prev_axiov && axiov)
      check_eq("ifg_spacing", 32'(cyc - fall_cyc), 32'(IFG + 2));
    prev_txen  = txen_in;
    prev_axiov = axiov;
  endtask

  task automatic wait_ready(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      step();
      if (bus.req_ready != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      step();
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic run_frame(input int idx, input logic [31:0] data, input string tag);
    bit ok;
    bus.req_data[32*idx +: 32] = data;
    bus.req_valid              = 2'b01 << idx;
    wait_ready(200, ok);
    check_eq({tag, "_ready_to"}, 32'(ok), 32'd1);
    bus.req_valid = '0;
    wait_idle(300, ok);
    check_eq({tag, "_idle_to"}, 32'(ok), 32'd1);
  endtask

  logic [1:0] exp_dib [16];

  initial begin
    bit ok;
    int n;
    exp_dib = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1,
                2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
    rst           = 1'b1;
    tether_en     = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset state
    repeat (3) step();
    check_eq("rst_axiov", 32'(axiov), 32'd0);
    check_eq("rst_axiod", 32'(axiod), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_idx), 32'd1);
    check_eq("rst_frames", 32'(frames_sent), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    step();

    // Single word from requester 0: FEEDBEEF as 16 dibits MSB first
    rdy0 = 0;
    bus.req_data[31:0] = 32'hFEEDBEEF;
    bus.req_valid      = 2'b01;
    step();
    check_eq("t2_ready", 32'(bus.req_ready), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd1);
    check_eq("t2_grant", 32'(grant_idx), 32'd0);
    bus.req_valid = '0;
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("t2_dibit%0d", k), 32'({axiov, axiod}), 32'({1'b1, exp_dib[k]}));
      step();
    end
    check_eq("t2_axiov_end", 32'(axiov), 32'd0);
    check_eq("t2_ready_cnt", 32'(rdy0), 32'd1);
    wait_idle(300, ok);
    check_eq("t2_idle_to", 32'(ok), 32'd1);
    check_eq("t2_frames", 32'(frames_sent), 32'd1);

    // Reset held 3 cycles in the middle of SEND
    rdy1 = 0;
    bus.req_data[63:32] = 32'h12345678;
    bus.req_valid       = 2'b10;
    step();
    bus.req_valid = '0;
    repeat (5) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_eq("t1_axiov", 32'(axiov), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_grant", 32'(grant_idx), 32'd1);
    check_eq("t1_frames", 32'(frames_sent), 32'd0);
    repeat (5) step();
    check_eq("t1_ready_cnt", 32'(rdy1), 32'd1);
    check_eq("t1_still_idle", 32'(busy), 32'd0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    fall_seen = 1'b0;
    ifg_chk   = 1'b1;
    bus.req_data  = {32'h22222222, 32'h11111111};
    bus.req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_ready(300, ok);
      check_eq($sformatf("t3_ready_to%0d", f), 32'(ok), 32'd1);
      check_eq($sformatf("t3_ready%0d", f), 32'(bus.req_ready), (f % 2 == 0) ? 32'd1 : 32'd2);
      check_eq($sformatf("t3_grant%0d", f), 32'(grant_idx), 32'(f % 2));
      check_eq($sformatf("t3_dibit0_%0d", f), 32'(axiod), (f % 2 == 0) ? 32'd0 : 32'd0);
      if (f == 3) bus.req_valid = '0;
    end
    wait_idle(300, ok);
    check_eq("t3_idle_to", 32'(ok), 32'd1);
    check_eq("t3_frames", 32'(frames_sent), 32'd4);
    ifg_chk = 1'b0;

    // Requester 1 raises valid while requester 0 is being sent
    rdy0 = 0;
    rdy1 = 0;
    bus.req_data[31:0] = 32'h0F0F0F0F;
    bus.req_valid      = 2'b01;
    wait_ready(200, ok);
    check_eq("t4_ready0_to", 32'(ok), 32'd1);
    check_eq("t4_ready0", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    repeat (4) step();
    bus.req_data[63:32] = 32'hA5A55A5A;
    bus.req_valid       = 2'b10;
    wait_ready(300, ok);
    check_eq("t4_ready1_to", 32'(ok), 32'd1);
    check_eq("t4_ready1", 32'(bus.req_ready), 32'd2);
    check_eq("t4_grant1", 32'(grant_idx), 32'd1);
    check_eq("t4_dibit0", 32'(axiod), 32'd2);
    bus.req_valid = '0;
    wait_idle(300, ok);
    check_eq("t4_idle_to", 32'(ok), 32'd1);
    check_eq("t4_cnt0", 32'(rdy0), 32'd1);
    check_eq("t4_cnt1", 32'(rdy1), 32'd1);
    check_eq("t4_frames", 32'(frames_sent), 32'd6);

    // Frame counter wrap: preload 0xFFFF, next frame reads 0x0000
    force dut.frames_sent_q = 16'hFFFF;
    step();
    release dut.frames_sent_q;
    step();
    run_frame(0, 32'hC0FFEE00, "t5a");
    check_eq("t5_wrap", 32'(frames_sent), 32'h0000);
    run_frame(1, 32'h00000001, "t5b");
    check_eq("t5_after_wrap", 32'(frames_sent), 32'h0001);

`ifdef ETH_TX_ARB_TIMEOUT_EN
    // txen never rises: WAIT_TX times out after 1024 clocks
    tether_en = 1'b0;
    check_eq("t6_timeout_init", 32'(tx_timeout), 32'd0);
    bus.req_data[31:0] = 32'h55AA55AA;
    bus.req_valid      = 2'b01;
    wait_ready(200, ok);
    check_eq("t6_ready_to", 32'(ok), 32'd1);
    bus.req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (!axiov) ok = 1'b1;
    end
    check_eq("t6_send_end_to", 32'(ok), 32'd1);
    n = 0;
    while (n < 1100 && !tx_timeout) begin
      step();
      n++;
    end
    check_eq("t6_timeout_cycles", 32'(n), 32'd1024);
    check_eq("t6_timeout_flag", 32'(tx_timeout), 32'd1);
    check_eq("t6_frames", 32'(frames_sent), 32'h0001);
    wait_idle(200, ok);
    check_eq("t6_idle_to", 32'(ok), 32'd1);
    check_eq("t6_sticky", 32'(tx_timeout), 32'd1);
    tether_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
